// File: rtl/sync_filter_bank.sv
// -----------------------------------------------------------------------------
// sync_filter_bank
//
// Gateway front end for the interrupt controller. Every asynchronous input
// line is brought into the clk_i domain by a DEPTH-stage flop synchroniser.
// It then passes through a stability filter with a programmable length, and
// finally through an edge detector. Each channel has its own filter counter
// and operates independently. All channels share one filter length.
//
// Parameters
//   NUM_CH  number of independent channels (>= 1)
//   DEPTH   synchroniser flop stages per channel (>= 2)
//   FILT_W  width of filt_len_i and of each stability counter (>= 1)
//
// Ports
//   clk_i        in   1       block clock
//   rst_i        in   1       asynchronous active-high reset, released
//                             synchronously by the surrounding reset logic
//   din_i        in   NUM_CH  raw asynchronous inputs
//   filt_len_i   in   FILT_W  stability threshold (quasi-static). A new
//                             level is accepted once the synchronised
//                             value has differed for filt_len_i+1 cycles
//   edge_mode_i  in   NUM_CH  per channel event select:
//                             0 = level, 1 = rising edge
//   sync_o       out  NUM_CH  synchronised, unfiltered value (last stage)
//   level_o      out  NUM_CH  filtered level
//   rise_o       out  NUM_CH  one-cycle pulse, coincident with level_o 0->1
//   fall_o       out  NUM_CH  one-cycle pulse, coincident with level_o 1->0
//   evt_o        out  NUM_CH  edge_mode_i ? rise_o : level_o
// -----------------------------------------------------------------------------
module sync_filter_bank #(
    parameter int NUM_CH = 32,
    parameter int DEPTH  = 2,
    parameter int FILT_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NUM_CH-1:0] din_i,
    input  logic [FILT_W-1:0] filt_len_i,
    input  logic [NUM_CH-1:0] edge_mode_i,
    output logic [NUM_CH-1:0] sync_o,
    output logic [NUM_CH-1:0] level_o,
    output logic [NUM_CH-1:0] rise_o,
    output logic [NUM_CH-1:0] fall_o,
    output logic [NUM_CH-1:0] evt_o
);

    localparam logic [FILT_W-1:0] CNT_ZERO = FILT_W'(0);
    localparam logic [FILT_W-1:0] CNT_ONE  = FILT_W'(1);

    // Stage 0 captures din_i. Stage DEPTH-1 is the synchronised value.
    logic [DEPTH-1:0][NUM_CH-1:0]  sync_q;
    logic [DEPTH-1:0][NUM_CH-1:0]  sync_d;

    // Per-channel stability counters.
    logic [NUM_CH-1:0][FILT_W-1:0] cnt_q;
    logic [NUM_CH-1:0][FILT_W-1:0] cnt_d;

    logic [NUM_CH-1:0]             level_q;
    logic [NUM_CH-1:0]             level_d;
    logic [NUM_CH-1:0]             rise_q;
    logic [NUM_CH-1:0]             rise_d;
    logic [NUM_CH-1:0]             fall_q;
    logic [NUM_CH-1:0]             fall_d;

    // Shift every channel's synchroniser chain by one stage.
    always_comb begin
        sync_d = {sync_q[DEPTH-2:0], din_i};
    end

    // Stability filter and edge detection, one independent slice per channel.
    always_comb begin
        level_d = level_q;
        rise_d  = '0;
        fall_d  = '0;
        cnt_d   = cnt_q;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (sync_q[DEPTH-1][ch] == level_q[ch]) begin
                // Agreement discards any partial excursion.
                cnt_d[ch] = CNT_ZERO;
            end else if (cnt_q[ch] >= filt_len_i) begin
                // Use >= rather than == so that lowering filt_len_i
                // mid-count takes effect on the next differing edge.
                level_d[ch] = sync_q[DEPTH-1][ch];
                cnt_d[ch]   = CNT_ZERO;
                rise_d[ch]  = sync_q[DEPTH-1][ch];
                fall_d[ch]  = ~sync_q[DEPTH-1][ch];
            end else begin
                // The counter stays below filt_len_i, so it cannot wrap.
                cnt_d[ch] = cnt_q[ch] + CNT_ONE;
            end
        end
    end

    // State registers for synchroniser, filter and edge pulses.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // Output view. evt_o is a pure mux of registered state, so a change
    // to edge_mode_i cannot create a pulse or disturb the filter.
    always_comb begin
        sync_o  = sync_q[DEPTH-1];
        level_o = level_q;
        rise_o  = rise_q;
        fall_o  = fall_q;
        evt_o   = (edge_mode_i & rise_q) | (~edge_mode_i & level_q);
    end

endmodule

// File: tb/tb_sync_filter_bank.sv
// Bench for sync_filter_bank. Two instances are used: DEPTH=2 is the main
// one, and DEPTH=3 is used for the latency sweep. Stimulus tasks push every
// expected rise/fall pulse into exp_q. A monitor pops one entry for each
// pulse the DUTs present and compares cycle, instance, channel and kind.
module tb_sync_filter_bank;

    localparam int NCH = 32;
    localparam int FW  = 4;

    typedef struct {
        int cyc;
        int inst;
        int ch;
        bit is_fall;
    } evt_t;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [NCH-1:0]  din2 = '1;
    logic [NCH-1:0]  din3 = '0;
    logic [FW-1:0]   flen = 4'd0;
    logic [NCH-1:0]  mode2 = '0;
    logic [NCH-1:0]  mode3 = '0;

    logic [NCH-1:0]  sync2, lvl2, rise2, fall2, evt2;
    logic [NCH-1:0]  sync3, lvl3, rise3, fall3, evt3;

    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    evt_t exp_q[$];
    evt_t mon_e;

    sync_filter_bank #(.NUM_CH(NCH), .DEPTH(2), .FILT_W(FW)) dut2 (
        .clk_i(clk), .rst_i(rst), .din_i(din2), .filt_len_i(flen),
        .edge_mode_i(mode2), .sync_o(sync2), .level_o(lvl2),
        .rise_o(rise2), .fall_o(fall2), .evt_o(evt2)
    );

    sync_filter_bank #(.NUM_CH(NCH), .DEPTH(3), .FILT_W(FW)) dut3 (
        .clk_i(clk), .rst_i(rst), .din_i(din3), .filt_len_i(flen),
        .edge_mode_i(mode3), .sync_o(sync3), .level_o(lvl3),
        .rise_o(rise3), .fall_o(fall3), .evt_o(evt3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
    endtask

    task automatic push(input int c, input int inst, input int ch, input bit is_fall);
        evt_t e;
        e.cyc = c; e.inst = inst; e.ch = ch; e.is_fall = is_fall;
        exp_q.push_back(e);
    endtask

    // Advance to just after the next rising edge (input drive point).
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait until the negedge sample point of cycle t.
    task automatic at_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Scoreboard monitor: every presented pulse must match the queue head.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            n_chk++;
            $display("FAIL sb_missed: no pulse seen, expected inst=%0d ch=%0d fall=%0d at cyc %0d",
                     exp_q[0].inst, exp_q[0].ch, exp_q[0].is_fall, exp_q[0].cyc);
            void'(exp_q.pop_front());
        end
        for (int inst = 0; inst < 2; inst++) begin
            for (int ch = 0; ch < NCH; ch++) begin
                logic r, f;
                r = (inst == 0) ? rise2[ch] : rise3[ch];
                f = (inst == 0) ? fall2[ch] : fall3[ch];
                if (r && f) begin
                    n_chk++;
                    $display("FAIL sb_both: rise and fall both 1 on inst=%0d ch=%0d at cyc %0d, expected at most one",
                             inst, ch, cyc);
                end
                if (r || f) begin
                    n_chk++;
                    if (exp_q.size() == 0) begin
                        $display("FAIL sb_unexpected: pulse inst=%0d ch=%0d fall=%0d at cyc %0d, expected none",
                                 inst, ch, f, cyc);
                    end else begin
                        mon_e = exp_q.pop_front();
                        if (mon_e.cyc == cyc && mon_e.inst == inst && mon_e.ch == ch && mon_e.is_fall == f)
                            n_pass++;
                        else
                            $display("FAIL sb_event: got inst=%0d ch=%0d fall=%0d cyc=%0d, expected inst=%0d ch=%0d fall=%0d cyc=%0d",
                                     inst, ch, f, cyc, mon_e.inst, mon_e.ch, mon_e.is_fall, mon_e.cyc);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int cnt_a;
        int cnt_b;
        logic hi;
        logic [NCH-1:0] old;
        int flens [3] = '{0, 1, 5};

        // ---------------- reset / idle, din all ones ----------------
        #1 rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rst_outputs", {sync2, lvl2, rise2, fall2, evt2}, 64'd0);
        end
        tick();
        rst = 1'b0;
        c = cyc;
        for (int ch = 0; ch < NCH; ch++) push(c + 3, 0, ch, 1'b0);
        at_cyc(c + 2); chk("rel_lvl_early", lvl2, 64'd0);
        at_cyc(c + 3); chk("rel_lvl", lvl2, 64'hFFFF_FFFF);
                       chk("rel_evt", evt2, 64'hFFFF_FFFF);
        at_cyc(c + 4); chk("rel_rise_1cyc", rise2, 64'd0);

        // All channels fall together.
        tick();
        din2 = '0;
        c = cyc;
        for (int ch = 0; ch < NCH; ch++) push(c + 3, 0, ch, 1'b1);
        at_cyc(c + 3); chk("all_fall_lvl", lvl2, 64'd0);
        at_cyc(c + 5);

        // ---------------- latency sweep, DEPTH=3, ch0 ----------------
        foreach (flens[i]) begin
            tick();
            flen = 4'(flens[i]);
            din3[0] = 1'b1;
            c = cyc;
            push(c + 4 + flens[i], 1, 0, 1'b0);
            at_cyc(c + 3 + flens[i]); chk("lat_lvl_pre", {63'd0, lvl3[0]}, 64'd0);
            at_cyc(c + 4 + flens[i]); chk("lat_lvl", {63'd0, lvl3[0]}, 64'd1);
            tick();
            din3[0] = 1'b0;
            c = cyc;
            push(c + 4 + flens[i], 1, 0, 1'b1);
            at_cyc(c + 5 + flens[i]);
        end

        // ---------------- glitch reject, flen=3, ch5 ----------------
        tick();
        flen = 4'd3;
        din2[5] = 1'b1;
        repeat (3) tick();
        din2[5] = 1'b0;
        hi = 1'b0;
        repeat (12) begin
            @(negedge clk);
            hi = hi | lvl2[5] | rise2[5] | evt2[5];
        end
        chk("glitch3_reject", {63'd0, hi}, 64'd0);

        tick();
        din2[5] = 1'b1;
        c = cyc;
        push(c + 6, 0, 5, 1'b0);
        push(c + 10, 0, 5, 1'b1);
        repeat (4) tick();
        din2[5] = 1'b0;
        cnt_a = 0;
        repeat (12) begin
            @(negedge clk);
            if (lvl2[5]) cnt_a++;
        end
        chk("glitch4_width", 64'(cnt_a), 64'd4);

        // ---------------- mode select ch7 edge, ch8 level ----------------
        tick();
        flen = 4'd0;
        mode2[7] = 1'b1;
        mode2[8] = 1'b0;
        din2[7] = 1'b1;
        din2[8] = 1'b1;
        c = cyc;
        push(c + 3, 0, 7, 1'b0);
        push(c + 3, 0, 8, 1'b0);
        cnt_a = 0;
        cnt_b = 0;
        fork
            begin
                repeat (10) tick();
                din2[7] = 1'b0;
                din2[8] = 1'b0;
                push(cyc + 3, 0, 7, 1'b1);
                push(cyc + 3, 0, 8, 1'b1);
            end
            begin
                repeat (18) begin
                    @(negedge clk);
                    if (evt2[7]) cnt_a++;
                    if (evt2[8]) cnt_b++;
                end
            end
        join
        chk("mode_edge_pulses", 64'(cnt_a), 64'd1);
        chk("mode_level_width", 64'(cnt_b), 64'd10);

        // ---------------- threshold change mid-count, ch2 ----------------
        tick();
        flen = 4'd7;
        din2[2] = 1'b1;
        c = cyc;
        repeat (6) tick();
        flen = 4'd2;
        push(c + 7, 0, 2, 1'b0);
        at_cyc(c + 6); chk("thr_lvl_pre", {63'd0, lvl2[2]}, 64'd0);
        at_cyc(c + 7); chk("thr_lvl", {63'd0, lvl2[2]}, 64'd1);
        tick();
        din2[2] = 1'b0;
        c = cyc;
        push(c + 5, 0, 2, 1'b1);
        at_cyc(c + 6);

        // ---------------- reset mid-operation, ch3 pending, ch4 high ----------------
        tick();
        flen = 4'd3;
        din2[4] = 1'b1;
        c = cyc;
        push(c + 6, 0, 4, 1'b0);
        at_cyc(c + 7); chk("pre_rst_lvl4", {63'd0, lvl2[4]}, 64'd1);
        tick();
        din2[3] = 1'b1;
        repeat (4) tick();
        #2 rst = 1'b1;
        #1;
        chk("rst_async_clear", {sync2, lvl2, rise2, fall2, evt2}, 64'd0);
        tick();
        tick();
        rst = 1'b0;
        c = cyc;
        push(c + 6, 0, 3, 1'b0);
        push(c + 6, 0, 4, 1'b0);
        at_cyc(c + 5); chk("rst_requal_pre", lvl2, 64'd0);
        at_cyc(c + 6); chk("rst_requal_lvl", lvl2, 64'h0000_0018);
        at_cyc(c + 7);

        // ---------------- simultaneous toggle of all channels ----------------
        tick();
        flen = 4'd0;
        old = din2;
        din2 = ~din2;
        c = cyc;
        for (int ch = 0; ch < NCH; ch++) push(c + 3, 0, ch, old[ch]);
        at_cyc(c + 3); chk("toggle_all_lvl", lvl2, 64'hFFFF_FFE7);
        tick();
        din2 = '0;
        c = cyc;
        for (int ch = 0; ch < NCH; ch++) if (ch != 3 && ch != 4) push(c + 3, 0, ch, 1'b1);
        at_cyc(c + 3); chk("toggle_clear_lvl", lvl2, 64'd0);
        at_cyc(c + 8);

        chk("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
